lcd_hd44780_ctrl: RTL and testbench

LCD_HD44780_CTRL -- requirements
Module: lcd_hd44780_ctrl

---
 rtl/lcd_hd44780_ctrl_if.sv | 10 +
 rtl/lcd_hd44780_ctrl.sv | 179 +++++++++++++++++
 tb/tb_lcd_hd44780_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/lcd_hd44780_ctrl_if.sv
// rtl/lcd_hd44780_ctrl_if.sv - CPU-side byte write handshake for the HD44780 controller
interface lcd_hd44780_ctrl_if;
  logic       i_vld;
  logic       i_rs;
  logic [7:0] i_data;
  logic       o_rdy;

  modport master (output i_vld, output i_rs, output i_data, input  o_rdy);
  modport slave  (input  i_vld, input  i_rs, input  i_data, output o_rdy);
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
// rtl/lcd_hd44780_ctrl.sv - HD44780 write-only bus timing controller with power-up wait
// Optional power-up init byte sequence built when LCD_AUTO_INIT_EN is defined.
module lcd_hd44780_ctrl #(
  parameter int T_PWRUP_CYC = 750000,
  parameter int T_SETUP_CYC = 4,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 4,
  parameter int T_EXEC_CYC  = 2500,
  parameter int T_CLR_CYC   = 82000
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  lcd_hd44780_ctrl_if.slave        cpu,
  output logic                     o_init_done,
  output logic                     o_lcd_on,
  output logic                     o_lcd_rs,
  output logic                     o_lcd_rw,
  output logic                     o_lcd_en,
  output logic [7:0]               o_lcd_data
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int PH_MAX = max2(max2(max2(T_SETUP_CYC, T_EN_CYC), max2(T_HOLD_CYC, T_EXEC_CYC)), T_CLR_CYC);
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int PW_W   = $clog2(T_PWRUP_CYC + 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_IDLE, S_SETUP, S_EN_HI, S_HOLD, S_WAIT
  } state_t;

  state_t          r_state;
  logic [PW_W-1:0] r_pw_cnt;
  logic [PH_W-1:0] r_cnt;
  logic            r_rdy;
  logic            r_init_done;
  logic            r_lcd_on;
  logic            r_lcd_rs;
  logic            r_lcd_rw;
  logic            r_lcd_en;
  logic [7:0]      r_lcd_data;

  logic            w_long_wait;
  logic            w_wait_last;

  // Clear and home need the long execution time; only commands qualify, data bytes never do.
  assign w_long_wait = !r_lcd_rs && ((r_lcd_data == 8'h01) || (r_lcd_data == 8'h02) || (r_lcd_data == 8'h03));
  assign w_wait_last = w_long_wait ? (r_cnt == PH_W'(T_CLR_CYC - 1)) : (r_cnt == PH_W'(T_EXEC_CYC - 1));

`ifdef LCD_AUTO_INIT_EN
  logic [1:0] r_init_idx;
  logic [7:0] w_init_byte;

  always_comb begin
    w_init_byte = 8'h38;
    case (r_init_idx)
      2'd0: w_init_byte = 8'h38;
      2'd1: w_init_byte = 8'h0C;
      2'd2: w_init_byte = 8'h01;
      2'd3: w_init_byte = 8'h06;
      default: w_init_byte = 8'h38;
    endcase
  end
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_PWRUP;
      r_pw_cnt    <= '0;
      r_cnt       <= '0;
      r_rdy       <= 1'b0;
      r_init_done <= 1'b0;
      r_lcd_on    <= 1'b0;
      r_lcd_rs    <= 1'b0;
      r_lcd_rw    <= 1'b0;
      r_lcd_en    <= 1'b0;
      r_lcd_data  <= 8'h00;
`ifdef LCD_AUTO_INIT_EN
      r_init_idx  <= 2'd0;
`endif
    end else begin
      r_lcd_on <= 1'b1;
      r_lcd_rw <= 1'b0;
      case (r_state)
        S_PWRUP: begin
          if (r_pw_cnt == PW_W'(T_PWRUP_CYC - 1)) begin
`ifdef LCD_AUTO_INIT_EN
            r_state     <= S_INIT;
`else
            r_state     <= S_IDLE;
            r_init_done <= 1'b1;
            r_rdy       <= 1'b1;
`endif
          end else begin
            r_pw_cnt <= r_pw_cnt + 1'b1;
          end
        end
`ifdef LCD_AUTO_INIT_EN
        S_INIT: begin
          r_lcd_rs   <= 1'b0;
          r_lcd_data <= w_init_byte;
          r_cnt      <= '0;
          r_state    <= S_SETUP;
        end
`endif
        S_IDLE: begin
          if (cpu.i_vld && r_rdy) begin
            r_lcd_rs   <= cpu.i_rs;
            r_lcd_data <= cpu.i_data;
            r_rdy      <= 1'b0;
            r_cnt      <= '0;
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == PH_W'(T_SETUP_CYC - 1)) begin
            r_cnt    <= '0;
            r_lcd_en <= 1'b1;
            r_state  <= S_EN_HI;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_EN_HI: begin
          if (r_cnt == PH_W'(T_EN_CYC - 1)) begin
            r_cnt    <= '0;
            r_lcd_en <= 1'b0;
            r_state  <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (r_cnt == PH_W'(T_HOLD_CYC - 1)) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (w_wait_last) begin
            r_cnt <= '0;
`ifdef LCD_AUTO_INIT_EN
            if (r_init_done) begin
              r_rdy   <= 1'b1;
              r_state <= S_IDLE;
            end else if (r_init_idx == 2'd3) begin
              r_init_done <= 1'b1;
              r_rdy       <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_init_idx <= r_init_idx + 2'd1;
              r_state    <= S_INIT;
            end
`else
            r_rdy   <= 1'b1;
            r_state <= S_IDLE;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_PWRUP;
      endcase
    end
  end

  assign cpu.o_rdy   = r_rdy;
  assign o_init_done = r_init_done;
  assign o_lcd_on    = r_lcd_on;
  assign o_lcd_rs    = r_lcd_rs;
  assign o_lcd_rw    = r_lcd_rw;
  assign o_lcd_en    = r_lcd_en;
  assign o_lcd_data  = r_lcd_data;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// tb/tb_lcd_hd44780_ctrl.sv - directed vector bench for lcd_hd44780_ctrl
module tb_lcd_hd44780_ctrl;

`ifdef LCD_AUTO_INIT_EN
  localparam int EXP_RDY_EDGE = 77;
`else
  localparam int EXP_RDY_EDGE = 10;
`endif

  logic       clk = 1'b0;
  logic       i_reset;
  logic       o_init_done;
  logic       o_lcd_on;
  logic       o_lcd_rs;
  logic       o_lcd_rw;
  logic       o_lcd_en;
  logic [7:0] o_lcd_data;

  int n_cmp = 0;
  int n_bad = 0;

  lcd_hd44780_ctrl_if bus ();

  lcd_hd44780_ctrl #(
    .T_PWRUP_CYC (10),
    .T_SETUP_CYC (2),
    .T_EN_CYC    (3),
    .T_HOLD_CYC  (2),
    .T_EXEC_CYC  (5),
    .T_CLR_CYC   (20)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .cpu         (bus),
    .o_init_done (o_init_done),
    .o_lcd_on    (o_lcd_on),
    .o_lcd_rs    (o_lcd_rs),
    .o_lcd_rw    (o_lcd_rw),
    .o_lcd_en    (o_lcd_en),
    .o_lcd_data  (o_lcd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         busy;
    int         en_start;
    int         en_width;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {17'd0, bus.o_rdy, o_init_done, o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_data};
  endfunction

  // Called right after reset is released on a falling edge.
  task automatic after_reset(input string tag);
    int         k;
    int         npulse;
    logic       prev_en;
    logic       rs_bad;
    logic [7:0] pd[4];
    logic [7:0] exp_init[4];
    exp_init[0] = 8'h38; exp_init[1] = 8'h0C; exp_init[2] = 8'h01; exp_init[3] = 8'h06;
    for (int i = 0; i < 4; i++) pd[i] = 8'h00;
    @(negedge clk);
    k = 1;
    chk({tag, " lcd_on first edge"}, o_lcd_on, 1);
    chk({tag, " en low in pwrup"}, o_lcd_en, 0);
    npulse = 0; prev_en = 1'b0; rs_bad = 1'b0;
    while (!bus.o_rdy && k < 500) begin
      if (o_lcd_en && !prev_en) begin
        if (npulse < 4) pd[npulse] = o_lcd_data;
        npulse++;
        if (o_lcd_rs) rs_bad = 1'b1;
      end
      prev_en = o_lcd_en;
      @(negedge clk);
      k++;
    end
    chk({tag, " rdy edge"}, k, EXP_RDY_EDGE);
    chk({tag, " init_done"}, o_init_done, 1);
`ifdef LCD_AUTO_INIT_EN
    chk({tag, " init pulses"}, npulse, 4);
    chk({tag, " init rs"}, rs_bad, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("%s init byte %0d", tag, i), pd[i], exp_init[i]);
`else
    chk({tag, " no init pulses"}, npulse, 0);
`endif
  endtask

  task automatic do_write(input logic rs, input logic [7:0] data,
                          output int busy, output int en_start, output int en_width, output int unstable);
    @(negedge clk);
    bus.i_vld = 1'b1; bus.i_rs = rs; bus.i_data = data;
    @(posedge clk);
    #1;
    bus.i_vld = 1'b0; bus.i_data = ~data; bus.i_rs = ~rs;
    busy = 0; en_start = -1; en_width = 0; unstable = 0;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (bus.o_rdy) break;
      busy++;
      if (o_lcd_en) begin
        if (en_start < 0) en_start = j;
        en_width++;
      end
      if (o_lcd_rs !== rs || o_lcd_data !== data || o_lcd_rw !== 1'b0) unstable++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy, en_start, en_width, unstable, k, bad;

    vecs[0] = '{1'b1, 8'h41, 12, 2, 3};
    vecs[1] = '{1'b0, 8'h01, 27, 2, 3};
    vecs[2] = '{1'b0, 8'h02, 27, 2, 3};
    vecs[3] = '{1'b0, 8'h03, 27, 2, 3};
    vecs[4] = '{1'b0, 8'h04, 12, 2, 3};
    vecs[5] = '{1'b0, 8'h00, 12, 2, 3};
    vecs[6] = '{1'b1, 8'h01, 12, 2, 3};
    vecs[7] = '{1'b1, 8'h03, 12, 2, 3};
    vecs[8] = '{1'b0, 8'h38, 12, 2, 3};

    i_reset = 1'b1;
    bus.i_vld = 1'b0; bus.i_rs = 1'b0; bus.i_data = 8'h00;
    repeat (3) begin
      @(negedge clk);
      chk("outputs in reset", all_outs(), 0);
    end
    i_reset = 1'b0;
    after_reset("pwrup");

    for (int v = 0; v < 9; v++) begin
      chk($sformatf("vec%0d rdy before", v), bus.o_rdy, 1);
      do_write(vecs[v].rs, vecs[v].data, busy, en_start, en_width, unstable);
      chk($sformatf("vec%0d busy", v), busy, vecs[v].busy);
      chk($sformatf("vec%0d en start", v), en_start, vecs[v].en_start);
      chk($sformatf("vec%0d en width", v), en_width, vecs[v].en_width);
      chk($sformatf("vec%0d pins stable", v), unstable, 0);
    end

    // Back-to-back: i_vld held high, second byte only taken once ready returns.
    @(negedge clk);
    bus.i_vld = 1'b1; bus.i_rs = 1'b1; bus.i_data = 8'h48;
    @(posedge clk);
    #1;
    bus.i_data = 8'h49;
    k = 0; bad = 0;
    while (k < 200) begin
      @(negedge clk);
      if (bus.o_rdy) break;
      k++;
      if (o_lcd_data !== 8'h48) bad++;
    end
    chk("b2b first busy", k, 12);
    chk("b2b data held while busy", bad, 0);
    chk("b2b data at rdy", o_lcd_data, 8'h48);
    @(negedge clk);
    chk("b2b second accepted rdy", bus.o_rdy, 0);
    chk("b2b second data", o_lcd_data, 8'h49);
    bus.i_vld = 1'b0;
    k = 1;
    while (!bus.o_rdy && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("b2b second busy", k, 13);

    // Reset while EN is high.
    @(negedge clk);
    bus.i_vld = 1'b1; bus.i_rs = 1'b1; bus.i_data = 8'h55;
    @(posedge clk);
    #1;
    bus.i_vld = 1'b0;
    k = 0;
    while (!o_lcd_en && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("en reached before reset", o_lcd_en, 1);
    #2;
    i_reset = 1'b1;
    #1;
    chk("en async clear", o_lcd_en, 0);
    chk("outputs async clear", all_outs(), 0);
    @(negedge clk);
    @(negedge clk);
    chk("outputs held in reset", all_outs(), 0);
    i_reset = 1'b0;
    after_reset("replay");

    do_write(1'b1, 8'h5A, busy, en_start, en_width, unstable);
    chk("post replay busy", busy, 12);
    chk("post replay en start", en_start, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
